mem_test_sequencer: RTL and testbench
=====================================

MEM_TEST_SEQUENCER -- requirements
Module: mem_test_sequencer

Interface
REQ-001 SHALL have parameter C_RUN_CNT_WIDTH, default 16, width of the run counters.
REQ-002 SHALL have parameter C_CYC_CNT_WIDTH, default 48, width of the cycle counters.
REQ-003 SHALL have parameter C_TIMEOUT, default 2**24, the maximum cycles allowed per kernel run.
REQ-004 SHALL have a single clock and reset: ap_clk in 1, the clock. ap_rst_n in 1, reset, asynchronous, active-low.
REQ-005 SHALL have these host-side ports:
- start in 1: rising-edge launch.
- abort in 1: level; stop after the current run.
- num_runs in C_RUN_CNT_WIDTH: number of runs.
- base_addr in 64: first buffer address.
- run_stride in 64: address offset between runs.
- addr_increment_in in 32: kernel address step.
- mem_max_addr_in in 32: kernel address bound.
REQ-006 SHALL have these host-side status ports:
- busy out 1: a sequence is active.
- done out 1: one-cycle completion pulse.
- error out 1: sticky timeout flag.
- runs_done out C_RUN_CNT_WIDTH: runs completed.
- last_run_cycles out C_CYC_CNT_WIDTH: duration of the last run.
- total_cycles out C_CYC_CNT_WIDTH: sum of all run durations.
REQ-007 SHALL have these kernel-side ports:
- k_ap_start out 1.
- k_ap_done in 1: one-cycle pulse.
- k_ap_idle in 1.
- k_out_data out 64: buffer address.
- k_addr_increment out 32.
- k_mem_max_addr out 32.

Function
REQ-008 SHALL implement the FSM states IDLE, RUN, GAP and FIN, with all outputs registered.
REQ-009 SHALL detect a start rising edge only in IDLE; start edges in any other state SHALL be ignored.
REQ-010 On a start edge in IDLE, the block SHALL:
- latch num_runs, base_addr, run_stride, addr_increment_in and mem_max_addr_in;
- clear runs_done, total_cycles, last_run_cycles and error;
- set busy=1 on the next cycle.
REQ-011 On a start edge with num_runs=0, the block SHALL go IDLE->FIN, issue no kernel start, and assert done two cycles after the edge.
REQ-012 On a start edge with num_runs>0, the block SHALL go to RUN with k_ap_start=1 and k_out_data=base_addr on the next cycle, which is latency 1.
REQ-013 In RUN, k_ap_start SHALL stay 1 and the run cycle counter SHALL increment each cycle, starting at 1 on the first RUN cycle.
REQ-014 In RUN, on k_ap_done=1 the block SHALL:
- go to GAP;
- drive k_ap_start=0;
- increment runs_done;
- load last_run_cycles with the run counter;
- add the run counter to total_cycles, saturating at all-ones.
REQ-015 GAP SHALL last exactly one cycle with k_ap_start=0, which guarantees a rising edge for the kernel's start detector.
REQ-016 From GAP, if runs_done equals the latched num_runs, or abort=1, the block SHALL go to FIN; otherwise it SHALL set k_out_data = k_out_data + run_stride (mod 2^64) and return to RUN.
REQ-017 In RUN, if the run counter reaches C_TIMEOUT without k_ap_done, the block SHALL:
- set error=1;
- drive k_ap_start=0;
- go to FIN;
- leave runs_done and total_cycles unchanged.
REQ-018 If k_ap_done and the timeout occur on the same cycle, k_ap_done SHALL win: the run counts as complete and error stays 0.
REQ-019 abort while in RUN SHALL NOT cut the run short; it takes effect at the next GAP.
REQ-020 FIN SHALL assert done=1 for exactly one cycle, clear busy on the following cycle, and return to IDLE.
REQ-021 k_ap_done outside RUN SHALL be ignored.
REQ-022 k_addr_increment and k_mem_max_addr SHALL be the latched values, held constant while busy=1.
REQ-023 Status outputs SHALL hold their values after FIN until the next accepted start.
REQ-024 Counters SHALL NOT wrap: runs_done is bounded by num_runs, and the cycle counters saturate.

Reset
REQ-025 On ap_rst_n=0, all outputs SHALL reset asynchronously to 0 and the FSM to IDLE.
REQ-026 The reset values SHALL be: k_ap_start=0, busy=0, done=0, error=0, all counters 0, k_out_data=0.
REQ-027 Reset asserted mid-sequence SHALL abort immediately, with no done pulse generated.
REQ-028 Reset release SHALL be internally synchronized before it is used.
REQ-029 A start held high through reset release SHALL NOT launch a sequence; a fresh rising edge is required.

Verification
REQ-030 Bench: num_runs=3, base=0x1000, stride=0x4000, kernel done 10 cycles after each start rise. Required response:
- k_out_data sequence is 0x1000, 0x5000, 0x9000;
- exactly 3 k_ap_start rising edges;
- runs_done=3, last_run_cycles=10, total_cycles=30;
- one done pulse, error=0.
REQ-031 Bench: num_runs=0. Required response: no k_ap_start activity, and done two cycles after the start edge with runs_done=0.
REQ-032 Bench: C_TIMEOUT=16, kernel never signals done. Required response: k_ap_start falls after 16 RUN cycles, error=1, runs_done=0, one done pulse.
REQ-033 Bench: num_runs=5, abort pulsed during run 2. Required response: run 2 completes, runs_done=2, done asserted, no third start.
REQ-034 Bench: a start edge while busy, then ap_rst_n pulsed low mid-run. Required response:
- the extra start is ignored;
- reset drives all outputs to 0 immediately;
- no done pulse follows.
REQ-035 Bench: k_ap_done on the same cycle as the timeout (C_TIMEOUT=8, done at cycle 8). Required response: error=0, runs_done=1.

Source files
------------

// File: rtl/mem_test_sequencer.sv
// Launches a kernel num_runs times over a strided series of buffers, timing each
// run and flagging a run that exceeds C_TIMEOUT cycles without finishing.
module mem_test_sequencer #(
  parameter int unsigned C_RUN_CNT_WIDTH = 16,
  parameter int unsigned C_CYC_CNT_WIDTH = 48,
  parameter int unsigned C_TIMEOUT       = 2**24
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [C_RUN_CNT_WIDTH-1:0] num_runs,
  input  logic [63:0]                base_addr,
  input  logic [63:0]                run_stride,
  input  logic [31:0]                addr_increment_in,
  input  logic [31:0]                mem_max_addr_in,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [C_RUN_CNT_WIDTH-1:0] runs_done,
  output logic [C_CYC_CNT_WIDTH-1:0] last_run_cycles,
  output logic [C_CYC_CNT_WIDTH-1:0] total_cycles,
  output logic                       k_ap_start,
  input  logic                       k_ap_done,
  input  logic                       k_ap_idle,
  output logic [63:0]                k_out_data,
  output logic [31:0]                k_addr_increment,
  output logic [31:0]                k_mem_max_addr
);

  localparam logic [C_CYC_CNT_WIDTH-1:0] TIMEOUT_CNT = C_CYC_CNT_WIDTH'(C_TIMEOUT);

  typedef enum logic [1:0] {IDLE, RUN, GAP, FIN} state_e;

  logic [1:0] rst_sync_q;
  logic       rst_n;
  logic       unused_idle;

  state_e                     state_q, state_d;
  logic                       start_prev_q, start_prev_d;
  logic                       abort_pend_q, abort_pend_d;
  logic [C_RUN_CNT_WIDTH-1:0] num_runs_q, num_runs_d;
  logic [63:0]                stride_q, stride_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       error_q, error_d;
  logic [C_RUN_CNT_WIDTH-1:0] runs_done_q, runs_done_d;
  logic [C_CYC_CNT_WIDTH-1:0] last_q, last_d;
  logic [C_CYC_CNT_WIDTH-1:0] total_q, total_d;
  logic [C_CYC_CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
  logic                       kstart_q, kstart_d;
  logic [63:0]                kdata_q, kdata_d;
  logic [31:0]                kinc_q, kinc_d;
  logic [31:0]                kmax_q, kmax_d;

  logic                       start_edge;
  logic [C_CYC_CNT_WIDTH:0]   total_sum;
  logic [C_CYC_CNT_WIDTH-1:0] total_sat;
  logic [C_CYC_CNT_WIDTH-1:0] run_cnt_inc;

  assign unused_idle = k_ap_idle;

  // Assertion is immediate; release reaches the core two clocks later.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rst_sync_q <= '0;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign start_edge  = start & ~start_prev_q;
  assign total_sum   = {1'b0, total_q} + {1'b0, run_cnt_q};
  assign total_sat   = total_sum[C_CYC_CNT_WIDTH] ? '1 : total_sum[C_CYC_CNT_WIDTH-1:0];
  assign run_cnt_inc = (&run_cnt_q) ? run_cnt_q : run_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    start_prev_d = start;
    abort_pend_d = abort_pend_q;
    num_runs_d   = num_runs_q;
    stride_d     = stride_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    runs_done_d  = runs_done_q;
    last_d       = last_q;
    total_d      = total_q;
    run_cnt_d    = run_cnt_q;
    kstart_d     = kstart_q;
    kdata_d      = kdata_q;
    kinc_d       = kinc_q;
    kmax_d       = kmax_q;

    unique case (state_q)
      IDLE: begin
        busy_d   = 1'b0;
        kstart_d = 1'b0;
        if (start_edge) begin
          num_runs_d   = num_runs;
          stride_d     = run_stride;
          kinc_d       = addr_increment_in;
          kmax_d       = mem_max_addr_in;
          runs_done_d  = '0;
          last_d       = '0;
          total_d      = '0;
          error_d      = 1'b0;
          abort_pend_d = 1'b0;
          busy_d       = 1'b1;
          if (num_runs == '0) begin
            state_d = FIN;
          end else begin
            state_d   = RUN;
            kstart_d  = 1'b1;
            kdata_d   = base_addr;
            run_cnt_d = C_CYC_CNT_WIDTH'(1);
          end
        end
      end

      RUN: begin
        // A short abort pulse must still stop the sequence at the next gap.
        if (abort) abort_pend_d = 1'b1;
        if (k_ap_done) begin
          state_d     = GAP;
          kstart_d    = 1'b0;
          runs_done_d = runs_done_q + 1'b1;
          last_d      = run_cnt_q;
          total_d     = total_sat;
        end else if (run_cnt_q >= TIMEOUT_CNT) begin
          state_d  = FIN;
          kstart_d = 1'b0;
          error_d  = 1'b1;
        end else begin
          run_cnt_d = run_cnt_inc;
        end
      end

      GAP: begin
        if (runs_done_q == num_runs_q || abort || abort_pend_q) begin
          state_d = FIN;
        end else begin
          state_d   = RUN;
          kstart_d  = 1'b1;
          kdata_d   = kdata_q + stride_q;
          run_cnt_d = C_CYC_CNT_WIDTH'(1);
        end
      end

      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // start_prev resets high so a start held through reset is not an edge.
  always_ff @(posedge ap_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b1;
      abort_pend_q <= 1'b0;
      num_runs_q   <= '0;
      stride_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      runs_done_q  <= '0;
      last_q       <= '0;
      total_q      <= '0;
      run_cnt_q    <= '0;
      kstart_q     <= 1'b0;
      kdata_q      <= '0;
      kinc_q       <= '0;
      kmax_q       <= '0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      abort_pend_q <= abort_pend_d;
      num_runs_q   <= num_runs_d;
      stride_q     <= stride_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      runs_done_q  <= runs_done_d;
      last_q       <= last_d;
      total_q      <= total_d;
      run_cnt_q    <= run_cnt_d;
      kstart_q     <= kstart_d;
      kdata_q      <= kdata_d;
      kinc_q       <= kinc_d;
      kmax_q       <= kmax_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign runs_done        = runs_done_q;
  assign last_run_cycles  = last_q;
  assign total_cycles     = total_q;
  assign k_ap_start       = kstart_q;
  assign k_out_data       = kdata_q;
  assign k_addr_increment = kinc_q;
  assign k_mem_max_addr   = kmax_q;

endmodule

// File: tb/tb_mem_test_sequencer.sv
// Bench for mem_test_sequencer: a row table of whole sequences plus hand-built
// reset/extra-start cases; kernel addresses are scoreboarded per start edge.
module tb_mem_test_sequencer;

  logic        clk;
  logic        ap_rst_n;
  logic        start;
  logic        abort;
  logic [15:0] num_runs;
  logic [63:0] base_addr;
  logic [63:0] run_stride;
  logic [31:0] inc_in;
  logic [31:0] max_in;

  logic        busy, done, error, k_ap_start, k_done, k_idle;
  logic [15:0] runs_done;
  logic [47:0] last_run_cycles, total_cycles;
  logic [63:0] k_out_data;
  logic [31:0] k_addr_increment, k_mem_max_addr;

  logic        busy8, done8, error8, k_ap_start8, k_done8, k_idle8;
  logic [15:0] runs_done8;
  logic [47:0] last8, total8;
  logic [63:0] k_out_data8;
  logic [31:0] k_inc8, k_max8;

  mem_test_sequencer #(.C_TIMEOUT(16)) dut (
    .ap_clk(clk), .ap_rst_n(ap_rst_n), .start(start), .abort(abort),
    .num_runs(num_runs), .base_addr(base_addr), .run_stride(run_stride),
    .addr_increment_in(inc_in), .mem_max_addr_in(max_in),
    .busy(busy), .done(done), .error(error), .runs_done(runs_done),
    .last_run_cycles(last_run_cycles), .total_cycles(total_cycles),
    .k_ap_start(k_ap_start), .k_ap_done(k_done), .k_ap_idle(k_idle),
    .k_out_data(k_out_data), .k_addr_increment(k_addr_increment),
    .k_mem_max_addr(k_mem_max_addr)
  );

  mem_test_sequencer #(.C_TIMEOUT(8)) dut8 (
    .ap_clk(clk), .ap_rst_n(ap_rst_n), .start(start), .abort(abort),
    .num_runs(num_runs), .base_addr(base_addr), .run_stride(run_stride),
    .addr_increment_in(inc_in), .mem_max_addr_in(max_in),
    .busy(busy8), .done(done8), .error(error8), .runs_done(runs_done8),
    .last_run_cycles(last8), .total_cycles(total8),
    .k_ap_start(k_ap_start8), .k_ap_done(k_done8), .k_ap_idle(k_idle8),
    .k_out_data(k_out_data8), .k_addr_increment(k_inc8),
    .k_mem_max_addr(k_max8)
  );

  typedef struct {
    logic [63:0] n;
    logic [63:0] base;
    logic [63:0] stride;
    int          kd;
    int          kd8;
    int          abort_run;
    int          exp_starts;
    logic [63:0] exp_runs;
    logic [63:0] exp_last;
    logic [63:0] exp_total;
    logic [63:0] exp_err;
    int          exp_lat;
    int          exp_hi;
    logic [63:0] exp8_runs;
    logic [63:0] exp8_err;
  } row_t;

  row_t        rows[7];
  logic [63:0] exp_addr_q[$];
  logic [31:0] exp_inc, exp_max;
  int          n_cmp, n_fail;
  int          cyc, done_cnt, done_cyc, last_hi, hi_run;
  int          kdelay, kdelay8, abort_run, krun, kcnt, kcnt8;
  logic        force_done, prev_ks;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever @(posedge clk) cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Kernel model: done pulses on the kd-th cycle start is seen high; abort pulse mid-run.
  initial begin
    k_done = 1'b0; k_done8 = 1'b0; abort = 1'b0; k_idle = 1'b1; k_idle8 = 1'b1;
    kcnt = 0; kcnt8 = 0;
    forever begin
      @(negedge clk);
      if (k_ap_start) begin
        if (kcnt == 0) krun++;
        kcnt++;
      end else kcnt = 0;
      if (k_ap_start8) kcnt8++;
      else kcnt8 = 0;
      k_done  = force_done || (k_ap_start && kdelay != 0 && kcnt == kdelay);
      k_done8 = force_done || (k_ap_start8 && kdelay8 != 0 && kcnt8 == kdelay8);
      abort   = (abort_run != 0 && krun == abort_run && kcnt == 3);
      k_idle  = !k_ap_start;
      k_idle8 = !k_ap_start8;
    end
  end

  // Monitor: scoreboard pop on every k_ap_start rise, done pulses, start-high length.
  initial begin
    prev_ks = 1'b0; hi_run = 0;
    forever begin
      @(negedge clk);
      if (ap_rst_n) begin
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (k_ap_start && !prev_ks) begin
          check("start_expected", 64'(exp_addr_q.size() != 0), 64'd1);
          if (exp_addr_q.size() != 0) check("k_out_data", k_out_data, exp_addr_q.pop_front());
          check("k_addr_increment", 64'(k_addr_increment), 64'(exp_inc));
          check("k_mem_max_addr", 64'(k_mem_max_addr), 64'(exp_max));
        end
        if (k_ap_start) hi_run++;
        else if (prev_ks) begin
          last_hi = hi_run;
          hi_run  = 0;
        end
      end else hi_run = 0;
      prev_ks = k_ap_start;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"},  64'({busy, done, error, k_ap_start}), 64'd0);
    check({tag, "_runs"},   64'(runs_done), 64'd0);
    check({tag, "_last"},   64'(last_run_cycles), 64'd0);
    check({tag, "_total"},  64'(total_cycles), 64'd0);
    check({tag, "_kdata"},  k_out_data, 64'd0);
    check({tag, "_kcfg"},   64'({k_addr_increment, k_mem_max_addr}), 64'd0);
    check({tag, "_dut8"},   64'(|{busy8, done8, error8, k_ap_start8, runs_done8, last8,
                                    total8, k_out_data8, k_inc8, k_max8}), 64'd0);
  endtask

  task automatic run_row(input int idx, input row_t r);
    int c0;
    kdelay = r.kd; kdelay8 = r.kd8; abort_run = r.abort_run; krun = 0;
    exp_inc = 32'h10 + 32'(idx);
    exp_max = 32'h100 * 32'(idx + 1);
    for (int k = 0; k < r.exp_starts; k++) exp_addr_q.push_back(r.base + r.stride * 64'(k));
    done_cnt = 0; last_hi = 0; done_cyc = 0;
    @(negedge clk);
    num_runs = 16'(r.n); base_addr = r.base; run_stride = r.stride;
    inc_in = exp_inc; max_in = exp_max; start = 1'b1;
    @(negedge clk);
    c0 = cyc;
    check($sformatf("r%0d_busy_set", idx), 64'(busy), 64'd1);
    // Scramble the inputs: the sequence must run on the latched copies.
    num_runs = 16'd7; base_addr = 64'hDEAD_0000; run_stride = 64'h3;
    inc_in = '1; max_in = '0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3000 && done_cnt == 0; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    check($sformatf("r%0d_done_pulses", idx), 64'(done_cnt), 64'd1);
    check($sformatf("r%0d_done_latency", idx), 64'(done_cyc - c0), 64'(r.exp_lat));
    check($sformatf("r%0d_busy_clear", idx), 64'(busy), 64'd0);
    check($sformatf("r%0d_runs_done", idx), 64'(runs_done), r.exp_runs);
    check($sformatf("r%0d_last_cycles", idx), 64'(last_run_cycles), r.exp_last);
    check($sformatf("r%0d_total_cycles", idx), 64'(total_cycles), r.exp_total);
    check($sformatf("r%0d_error", idx), 64'(error), r.exp_err);
    check($sformatf("r%0d_start_high_len", idx), 64'(last_hi), 64'(r.exp_hi));
    check($sformatf("r%0d_starts_left", idx), 64'(exp_addr_q.size()), 64'd0);
    if (r.kd8 != 0) begin
      check($sformatf("r%0d_t8_runs_done", idx), 64'(runs_done8), r.exp8_runs);
      check($sformatf("r%0d_t8_error", idx), 64'(error8), r.exp8_err);
    end
    exp_addr_q.delete();
    repeat (20) @(negedge clk);
  endtask

  initial begin
    rows[0] = '{64'd3, 64'h1000, 64'h4000, 10, 0, 0, 3, 64'd3, 64'd10, 64'd30, 64'd0, 34, 10, 64'd0, 64'd0};
    rows[1] = '{64'd0, 64'h8000, 64'h10,   10, 0, 0, 0, 64'd0, 64'd0,  64'd0,  64'd0, 1,  0,  64'd0, 64'd0};
    rows[2] = '{64'd5, 64'h20000, 64'h100, 6,  0, 2, 2, 64'd2, 64'd6,  64'd12, 64'd0, 15, 6,  64'd0, 64'd0};
    rows[3] = '{64'd2, 64'h3000, 64'h40,   0,  0, 0, 1, 64'd0, 64'd0,  64'd0,  64'd1, 17, 16, 64'd0, 64'd0};
    rows[4] = '{64'd2, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 1, 0, 0, 2, 64'd2, 64'd1, 64'd2, 64'd0, 5, 1, 64'd0, 64'd0};
    rows[5] = '{64'd1, 64'h4000, 64'h0,    8,  8, 0, 1, 64'd1, 64'd8,  64'd8,  64'd0, 10, 8,  64'd1, 64'd0};
    rows[6] = '{64'd1, 64'h5000, 64'h0,    9,  9, 0, 1, 64'd1, 64'd9,  64'd9,  64'd0, 11, 9,  64'd0, 64'd1};

    n_cmp = 0; n_fail = 0; done_cnt = 0; done_cyc = 0; last_hi = 0;
    kdelay = 0; kdelay8 = 0; abort_run = 0; krun = 0; force_done = 1'b0;
    exp_inc = '0; exp_max = '0;
    ap_rst_n = 1'b0; start = 1'b1;
    num_runs = 16'd1; base_addr = '0; run_stride = '0; inc_in = '0; max_in = '0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    ap_rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("held_start_busy", 64'(busy), 64'd0);
    check("held_start_kstart", 64'(k_ap_start), 64'd0);
    start = 1'b0;

    force_done = 1'b1;
    repeat (3) @(negedge clk);
    force_done = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_kdone_runs", 64'(runs_done), 64'd0);
    check("idle_kdone_busy", 64'(busy), 64'd0);
    check("idle_kdone_pulses", 64'(done_cnt), 64'd0);

    for (int i = 0; i < 7; i++) run_row(i, rows[i]);

    // Extra start while busy, then reset in the middle of run 2.
    kdelay = 10; kdelay8 = 0; abort_run = 0; krun = 0; done_cnt = 0;
    exp_inc = 32'h77; exp_max = 32'h7700;
    for (int k = 0; k < 3; k++) exp_addr_q.push_back(64'h1000 + 64'h4000 * 64'(k));
    @(negedge clk);
    num_runs = 16'd3; base_addr = 64'h1000; run_stride = 64'h4000;
    inc_in = exp_inc; max_in = exp_max; start = 1'b1;
    @(negedge clk);
    num_runs = 16'd9; base_addr = 64'hBEEF_0000; run_stride = 64'h8;
    inc_in = 32'h1; max_in = 32'h2; start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 60 && runs_done == 16'd0; k++) @(negedge clk);
    check("extra_start_runs", 64'(runs_done), 64'd1);
    check("extra_start_last", 64'(last_run_cycles), 64'd10);
    for (int k = 0; k < 60 && !(krun == 2 && kcnt == 4); k++) @(negedge clk);
    check("midrst_in_run2", 64'(krun), 64'd2);
    ap_rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    check("midrst_starts_left", 64'(exp_addr_q.size()), 64'd1);
    exp_addr_q.delete();
    start = 1'b1;
    repeat (3) @(negedge clk);
    ap_rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_done", 64'(done_cnt), 64'd0);
    check("midrst_held_start", 64'(busy), 64'd0);
    start = 1'b0;
    repeat (2) @(negedge clk);

    run_row(7, rows[4]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
